// File: rtl/bias_ctrl_if.sv
// Unified-buffer read port used by bias_ctrl to fetch one bias word per column.
// req is a level held with a stable address until a beat; a beat transfers on a rising edge where req && valid.
interface bias_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ub_rd_req_out;
  logic [ADDR_W-1:0] ub_rd_addr_out;
  logic              ub_rd_valid_in;
  logic [DATA_W-1:0] ub_rd_data_in;

  modport master (
    output ub_rd_req_out,
    output ub_rd_addr_out,
    input  ub_rd_valid_in,
    input  ub_rd_data_in
  );

  modport slave (
    input  ub_rd_req_out,
    input  ub_rd_addr_out,
    output ub_rd_valid_in,
    output ub_rd_data_in
  );
endinterface

// File: rtl/bias_ctrl.sv
// Per-layer bias loader: fetches NUM_COLS bias words from the unified buffer,
// holds them for the columns and counts systolic rows per column to find layer end.
module bias_ctrl #(
  parameter int NUM_COLS = 2,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic [ADDR_W-1:0]          bias_base_addr_in,
  input  logic [15:0]                num_rows_in,
  bias_ctrl_if.master                ub,
  input  logic [NUM_COLS-1:0]        col_valid_in,
  output logic [NUM_COLS*DATA_W-1:0] bias_scalar_out,
  output logic                       busy_out,
  output logic                       ready_out,
  output logic                       layer_done_out,
  output logic                       err_out,
  output logic [1:0]                 state_dbg
);

  localparam int KW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         rows_q;
  logic [KW-1:0]       k_q;
  logic [DATA_W-1:0]   bias_q [NUM_COLS];
  logic [15:0]         cnt_q  [NUM_COLS];
  logic                done_q, err_q;
  logic                done_d, err_set;
  logic                start_acc, beat, last_beat, all_fin;
  logic [NUM_COLS-1:0] col_done, col_fin;

  // The done-pulse cycle still counts as the tail of the previous layer, so a start there is dropped.
  assign start_acc = (state_q == IDLE) && start_in && !done_q;
  assign beat      = (state_q == FETCH) && ub.ub_rd_valid_in;
  assign last_beat = beat && (k_q == K_LAST);

  always_comb begin
    col_done = '0;
    col_fin  = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      col_done[c] = (cnt_q[c] == rows_q);
      col_fin[c]  = col_done[c] || (col_valid_in[c] && ((cnt_q[c] + 16'd1) == rows_q));
    end
  end

  assign all_fin = &col_fin;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        err_set = |col_valid_in;
        if (start_acc) state_d = FETCH;
      end
      FETCH: begin
        err_set = |col_valid_in;
        if (last_beat) begin
          if (rows_q != 16'd0) begin
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ACTIVE: begin
        err_set = |(col_valid_in & col_done);
        if (all_fin) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      rows_q <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
        bias_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      done_q <= done_d;
      err_q  <= (start_acc ? 1'b0 : err_q) | err_set;
      if (start_acc) begin
        base_q <= bias_base_addr_in;
        rows_q <= num_rows_in;
        k_q    <= '0;
        for (int c = 0; c < NUM_COLS; c++) cnt_q[c] <= '0;
      end
      if (beat) begin
        bias_q[k_q] <= ub.ub_rd_data_in;
        k_q         <= last_beat ? '0 : k_q + KW'(1);
      end
      // Complete columns saturate; their extra valids only raise err.
      if (state_q == ACTIVE) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (col_valid_in[c] && !col_done[c]) cnt_q[c] <= cnt_q[c] + 16'd1;
        end
      end
    end
  end

  assign ub.ub_rd_req_out  = (state_q == FETCH);
  assign ub.ub_rd_addr_out = (state_q == FETCH) ? base_q + ADDR_W'(k_q) : '0;

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_bias
    assign bias_scalar_out[g*DATA_W +: DATA_W] = bias_q[g];
  end

  assign busy_out       = (state_q != IDLE);
  assign ready_out      = (state_q == ACTIVE);
  assign layer_done_out = done_q;
  assign err_out        = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Self-checking bench for bias_ctrl: table-driven layers plus hand-written
// sequences for error, start-collision and asynchronous-reset corner cases.
module tb_bias_ctrl;

  logic        clk;
  logic        rst;
  logic        start_in;
  logic [15:0] bias_base_addr_in;
  logic [15:0] num_rows_in;
  logic [1:0]  col_valid_in;
  logic [31:0] bias_scalar_out;
  logic        busy_out, ready_out, layer_done_out, err_out;
  logic [1:0]  state_dbg;

  bias_ctrl_if #(.ADDR_W(16), .DATA_W(16)) ub_if ();

  bias_ctrl #(.NUM_COLS(2), .DATA_W(16), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_in          (start_in),
    .bias_base_addr_in (bias_base_addr_in),
    .num_rows_in       (num_rows_in),
    .ub                (ub_if),
    .col_valid_in      (col_valid_in),
    .bias_scalar_out   (bias_scalar_out),
    .busy_out          (busy_out),
    .ready_out         (ready_out),
    .layer_done_out    (layer_done_out),
    .err_out           (err_out),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [15:0] exp_q[$];
  logic [31:0] cur_bias;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [15:0] base;
    logic [15:0] rows;
    logic [15:0] d0;
    logic [15:0] d1;
    int          dly;
    logic [31:0] exp_bias;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // driver tasks: all called at a falling edge, return at a falling edge
  task automatic do_start(input logic [15:0] base, input logic [15:0] rows);
    logic [15:0] a1;
    a1 = base + 16'd1;
    start_in          = 1'b1;
    bias_base_addr_in = base;
    num_rows_in       = rows;
    exp_q.push_back(base);
    exp_q.push_back(a1);
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic do_beat(input logic [15:0] data, input int dly);
    logic [15:0] ea;
    for (int i = 0; i < dly; i++) begin
      check("req_wait", ub_if.ub_rd_req_out, 1'b1);
      if (exp_q.size() > 0) check("addr_hold", ub_if.ub_rd_addr_out, exp_q[0]);
      @(negedge clk);
    end
    check("req_beat", ub_if.ub_rd_req_out, 1'b1);
    if (exp_q.size() == 0) begin
      check("addr_queue_empty", 1'b1, 1'b0);
    end else begin
      ea = exp_q.pop_front();
      check("addr_beat", ub_if.ub_rd_addr_out, ea);
    end
    ub_if.ub_rd_valid_in = 1'b1;
    ub_if.ub_rd_data_in  = data;
    @(negedge clk);
    ub_if.ub_rd_valid_in = 1'b0;
    ub_if.ub_rd_data_in  = 16'h0;
  endtask

  task automatic drive_cols(input logic [1:0] v);
    col_valid_in = v;
    @(negedge clk);
    col_valid_in = 2'b00;
  endtask

  task automatic run_layer(input vec_t v);
    int rem [2];
    int cyc;
    logic [1:0] cv;
    do_start(v.base, v.rows);
    check("busy_after_start", busy_out, 1'b1);
    do_beat(v.d0, v.dly);
    check("bias_after_beat0", bias_scalar_out, {cur_bias[31:16], v.d0});
    do_beat(v.d1, v.dly);
    check("bias_loaded", bias_scalar_out, v.exp_bias);
    check("ready_loaded", ready_out, v.exp_ready);
    check("req_drop", ub_if.ub_rd_req_out, 1'b0);
    cur_bias = v.exp_bias;
    if (v.rows != 16'd0) begin
      rem[0] = int'(v.rows);
      rem[1] = int'(v.rows);
      cyc = 0;
      while (rem[0] > 0 || rem[1] > 0) begin
        for (int c = 0; c < 2; c++) begin
          cv[c] = (rem[c] > 0) && (($urandom_range(0, 1) == 1) || cyc > 20);
          if (cv[c]) rem[c]--;
        end
        cyc++;
        drive_cols(cv);
        if (rem[0] > 0 || rem[1] > 0) check("no_early_done", layer_done_out, 1'b0);
      end
      check("err_clean", err_out, 1'b0);
    end
    check("layer_done", layer_done_out, 1'b1);
    check("busy_at_done", busy_out, 1'b0);
    check("ready_at_done", ready_out, 1'b0);
    @(negedge clk);
    check("done_single", layer_done_out, 1'b0);
    check("bias_held_idle", bias_scalar_out, cur_bias);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur_bias = 32'h0;
    rst = 1'b0;
    start_in = 1'b0;
    bias_base_addr_in = 16'h0;
    num_rows_in = 16'h0;
    col_valid_in = 2'b00;
    ub_if.ub_rd_valid_in = 1'b0;
    ub_if.ub_rd_data_in  = 16'h0;

    vecs[0] = '{16'h0010, 16'd3, 16'h0100, 16'hFF00, 0, 32'hFF00_0100, 1'b1};
    vecs[1] = '{16'h0010, 16'd3, 16'h0100, 16'hFF00, 5, 32'hFF00_0100, 1'b1};
    vecs[2] = '{16'h0200, 16'd0, 16'h1234, 16'h8765, 0, 32'h8765_1234, 1'b0};
    vecs[3] = '{16'hFFFF, 16'd2, 16'h7FFF, 16'h8000, 1, 32'h8000_7FFF, 1'b1};
    vecs[4] = '{16'h0100, 16'd6, 16'hAAAA, 16'h5555, 2, 32'h5555_AAAA, 1'b1};

    #3;
    check("rst_busy", busy_out, 1'b0);
    check("rst_ready", ready_out, 1'b0);
    check("rst_done", layer_done_out, 1'b0);
    check("rst_err", err_out, 1'b0);
    check("rst_req", ub_if.ub_rd_req_out, 1'b0);
    check("rst_addr", ub_if.ub_rd_addr_out, 16'h0);
    check("rst_bias", bias_scalar_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_layer(vecs[i]);

    // column valid during FETCH, start during ACTIVE, over-count on column 0
    do_start(16'h0050, 16'd3);
    col_valid_in = 2'b01;
    @(negedge clk);
    col_valid_in = 2'b00;
    check("err_fetch", err_out, 1'b1);
    do_beat(16'h1111, 0);
    do_beat(16'h2222, 0);
    cur_bias = 32'h2222_1111;
    check("bias_err_layer", bias_scalar_out, cur_bias);
    start_in = 1'b1;
    bias_base_addr_in = 16'h1234;
    num_rows_in = 16'd9;
    col_valid_in = 2'b11;
    @(negedge clk);
    start_in = 1'b0;
    col_valid_in = 2'b00;
    check("start_active_ignored", ready_out, 1'b1);
    drive_cols(2'b11);
    drive_cols(2'b01);
    check("col0_done_no_layer", layer_done_out, 1'b0);
    drive_cols(2'b01);
    check("err_sticky_overcount", err_out, 1'b1);
    check("no_done_overcount", layer_done_out, 1'b0);
    drive_cols(2'b10);
    check("done_after_err", layer_done_out, 1'b1);
    check("err_held", err_out, 1'b1);
    @(negedge clk);
    check("no_refetch", ub_if.ub_rd_req_out, 1'b0);
    check("idle_after_err_layer", busy_out, 1'b0);
    check("bias_unchanged", bias_scalar_out, cur_bias);

    // next start clears err; start colliding with the done pulse is dropped
    do_start(16'h0060, 16'd1);
    check("err_cleared", err_out, 1'b0);
    do_beat(16'h0A0A, 0);
    do_beat(16'h0B0B, 0);
    drive_cols(2'b11);
    check("done_short_layer", layer_done_out, 1'b1);
    start_in = 1'b1;
    bias_base_addr_in = 16'h0070;
    num_rows_in = 16'd1;
    @(negedge clk);
    check("start_on_done_ignored", busy_out, 1'b0);
    bias_base_addr_in = 16'h0080;
    num_rows_in = 16'd2;
    exp_q.push_back(16'h0080);
    exp_q.push_back(16'h0081);
    @(negedge clk);
    start_in = 1'b0;
    check("start_after_done_accepted", busy_out, 1'b1);
    do_beat(16'hC0DE, 0);
    do_beat(16'hBEEF, 0);
    check("bias_before_reset", bias_scalar_out, 32'hBEEF_C0DE);
    drive_cols(2'b11);

    // asynchronous reset mid-ACTIVE
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy_out, 1'b0);
    check("arst_ready", ready_out, 1'b0);
    check("arst_bias", bias_scalar_out, 32'h0);
    check("arst_err", err_out, 1'b0);
    check("arst_req", ub_if.ub_rd_req_out, 1'b0);
    check("arst_done", layer_done_out, 1'b0);
    ub_if.ub_rd_valid_in = 1'b1;
    ub_if.ub_rd_data_in  = 16'hDEAD;
    col_valid_in = 2'b11;
    @(negedge clk);
    col_valid_in = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    check("stale_valid_ignored", bias_scalar_out, 32'h0);
    check("no_done_after_reset", layer_done_out, 1'b0);
    check("idle_after_reset", state_dbg, 2'd0);
    ub_if.ub_rd_valid_in = 1'b0;
    ub_if.ub_rd_data_in  = 16'h0;
    @(negedge clk);
    check("addr_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
